// File: rtl/gru_step_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gru_step_sequencer_if                                                      |
// | Control/address bundle between the GRU step sequencer and its datapath.    |
// | Optional: GRU_STALL_CNT_EN adds stall_cnt.                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface gru_step_sequencer_if #(
    parameter int AW = 16,
    parameter int IW = 8
);
    logic          start;
    logic          busy;
    logic          done;
    logic          mac_clr;
    logic          mac_en;
    logic          mac_sel;
    logic [1:0]    gate;
    logic [IW-1:0] neuron;
    logic [IW-1:0] x_idx;
    logic [AW-1:0] bias_addr;
    logic [AW-1:0] w_addr;
    logic          act_valid;
    logic          act_ready;
    logic          state_we;
`ifdef GRU_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    modport master (
        input  start, act_ready,
        output busy, done, mac_clr, mac_en, mac_sel, gate, neuron, x_idx,
               bias_addr, w_addr, act_valid, state_we
`ifdef GRU_STALL_CNT_EN
        , output stall_cnt
`endif
    );

    modport slave (
        output start, act_ready,
        input  busy, done, mac_clr, mac_en, mac_sel, gate, neuron, x_idx,
               bias_addr, w_addr, act_valid, state_we
`ifdef GRU_STALL_CNT_EN
        , input stall_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/gru_step_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gru_step_sequencer                                                         |
// | Walks gates Z, R, H neuron by neuron: bias load, input MACs, recurrent     |
// | MACs, activation handshake. Optional: GRU_STALL_CNT_EN adds stall_cnt.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gru_step_sequencer #(
    parameter int NB_INPUTS  = 24,
    parameter int NB_NEURONS = 24,
    parameter int AW         = 16,
    parameter int IW         = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    gru_step_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BIAS    = 3'd1,
        ST_IN_MAC  = 3'd2,
        ST_REC_MAC = 3'd3,
        ST_ACT     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [IW-1:0] c_m_last = IW'(NB_INPUTS - 1);
    localparam logic [IW-1:0] c_n_last = IW'(NB_NEURONS - 1);
    localparam logic [AW-1:0] c_n      = AW'(NB_NEURONS);
    localparam logic [AW-1:0] c_row    = AW'(3 * NB_NEURONS);

    state_t        r_state,  w_state_nxt;
    logic [1:0]    r_gate,   w_gate_nxt;
    logic [IW-1:0] r_neuron, w_neuron_nxt;
    logic [IW-1:0] r_j,      w_j_nxt;
    logic [AW-1:0] r_bias_addr, w_bias_nxt;
    logic [AW-1:0] r_w_addr,    w_waddr_nxt;
    logic          w_handshake;

    assign w_handshake = (r_state == ST_ACT) && bus.act_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gate      <= 2'd0;
            r_neuron    <= '0;
            r_j         <= '0;
            r_bias_addr <= '0;
            r_w_addr    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gate      <= w_gate_nxt;
            r_neuron    <= w_neuron_nxt;
            r_j         <= w_j_nxt;
            r_bias_addr <= w_bias_nxt;
            r_w_addr    <= w_waddr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gate_nxt   = r_gate;
        w_neuron_nxt = r_neuron;
        w_j_nxt      = r_j;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt  = ST_BIAS;
                    w_gate_nxt   = 2'd0;
                    w_neuron_nxt = '0;
                    w_j_nxt      = '0;
                end
            end
            ST_BIAS: begin
                w_state_nxt = ST_IN_MAC;
                w_j_nxt     = '0;
            end
            ST_IN_MAC: begin
                if (r_j == c_m_last) begin
                    w_state_nxt = ST_REC_MAC;
                    w_j_nxt     = '0;
                end else begin
                    w_j_nxt = r_j + 1'b1;
                end
            end
            ST_REC_MAC: begin
                // j stays at N-1 through ACT so w_addr is held for the handshake
                if (r_j == c_n_last) begin
                    w_state_nxt = ST_ACT;
                end else begin
                    w_j_nxt = r_j + 1'b1;
                end
            end
            ST_ACT: begin
                if (bus.act_ready) begin
                    w_j_nxt = '0;
                    if (r_neuron == c_n_last) begin
                        w_neuron_nxt = '0;
                        if (r_gate == 2'd2) begin
                            w_gate_nxt  = 2'd0;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_gate_nxt  = r_gate + 2'd1;
                            w_state_nxt = ST_BIAS;
                        end
                    end else begin
                        w_neuron_nxt = r_neuron + 1'b1;
                        w_state_nxt  = ST_BIAS;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_gate_nxt   = 2'd0;
                w_neuron_nxt = '0;
                w_j_nxt      = '0;
            end
        endcase
        w_bias_nxt  = AW'(w_gate_nxt) * c_n + AW'(w_neuron_nxt);
        w_waddr_nxt = AW'(w_j_nxt) * c_row + w_bias_nxt;
    end

    assign bus.busy      = (r_state == ST_BIAS) || (r_state == ST_IN_MAC) ||
                           (r_state == ST_REC_MAC) || (r_state == ST_ACT);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.mac_clr   = (r_state == ST_BIAS);
    assign bus.mac_en    = (r_state == ST_IN_MAC) || (r_state == ST_REC_MAC);
    assign bus.mac_sel   = (r_state == ST_REC_MAC);
    assign bus.gate      = r_gate;
    assign bus.neuron    = r_neuron;
    assign bus.x_idx     = bus.mac_en ? r_j : '0;
    assign bus.bias_addr = r_bias_addr;
    assign bus.w_addr    = r_w_addr;
    assign bus.act_valid = (r_state == ST_ACT);
    assign bus.state_we  = w_handshake && (r_gate == 2'd2);

`ifdef GRU_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if ((r_state == ST_IDLE) && bus.start) begin
            r_stall_cnt <= 16'd0;
        end else if ((r_state == ST_ACT) && !bus.act_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_gru_step_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gru_step_sequencer                                                      |
// | Scoreboard bench: M=N=24 instance for steps/stalls/reset, M=N=1 instance.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_gru_step_sequencer;
    localparam int M     = 24;
    localparam int N     = 24;
    localparam int AW    = 16;
    localparam int IW    = 8;
    localparam int LAT   = 3 * N * (M + N + 2) + 1;
    localparam int STALL = 7;

    typedef struct {
        logic [1:0]  gate;
        logic [7:0]  neuron;
        logic [15:0] bias;
        logic [15:0] waddr;
        logic        we;
    } hs_t;

    typedef struct {
        int cyc;
        int busy_len;
    } done_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gru_step_sequencer_if #(.AW(AW), .IW(IW)) bus_a ();
    gru_step_sequencer_if #(.AW(AW), .IW(IW)) bus_b ();

    gru_step_sequencer #(.NB_INPUTS(M), .NB_NEURONS(N), .AW(AW), .IW(IW)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    gru_step_sequencer #(.NB_INPUTS(1), .NB_NEURONS(1), .AW(AW), .IW(IW)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    hs_t   exp_q[$];
    done_t done_q[$];

    task automatic push_step(input int start_cyc, input int stall);
        hs_t e;
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < N; i++) begin
                e.gate   = 2'(g);
                e.neuron = 8'(i);
                e.bias   = 16'(g * N + i);
                e.waddr  = 16'((N - 1) * 3 * N + g * N + i);
                e.we     = (g == 2);
                exp_q.push_back(e);
            end
        end
        done_q.push_back('{cyc: start_cyc + LAT + 3 * N * stall,
                           busy_len: LAT - 1 + 3 * N * stall});
    endtask

    // act_ready is held low for the first stall_cfg cycles of every ACT visit
    int stall_cfg = 0;
    int act_k     = 0;
    always @(posedge clk) begin
        #1;
        if (bus_a.act_valid) begin
            bus_a.act_ready = (act_k >= stall_cfg);
            act_k++;
        end else begin
            act_k = 0;
            bus_a.act_ready = (stall_cfg == 0);
        end
    end

    int          in_cnt = 0, rec_cnt = 0, busy_run = 0;
    int          hs_cnt = 0, we_cnt = 0, done_cnt = 0;
    logic        in_act = 1'b0;
    logic [49:0] act_ref;
    hs_t         cur;
    done_t       dexp;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_act   = 1'b0;
            busy_run = 0;
        end else begin
            if (bus_a.mac_clr) begin
                in_cnt  = 0;
                rec_cnt = 0;
                if (exp_q.size() == 0) check_value("bias_queue", exp_q.size(), 1);
                else begin
                    cur = exp_q[0];
                    check_value("bias_addr", bus_a.bias_addr, cur.bias);
                    check_value("bias_gate", bus_a.gate, cur.gate);
                    check_value("bias_neuron", bus_a.neuron, cur.neuron);
                    if (cur.gate == 2'd1 && cur.neuron == 8'd5) check_value("t2_bias", bus_a.bias_addr, 29);
                end
            end
            if (bus_a.mac_en && exp_q.size() != 0) begin
                cur = exp_q[0];
                if (!bus_a.mac_sel) begin
                    check_value("in_x_idx", bus_a.x_idx, in_cnt);
                    check_value("in_w_addr", bus_a.w_addr, in_cnt * 3 * N + cur.bias);
                    if (cur.gate == 2'd1 && cur.neuron == 8'd5 && in_cnt == 3)
                        check_value("t2_w_addr", bus_a.w_addr, 245);
                    in_cnt++;
                end else begin
                    check_value("rec_x_idx", bus_a.x_idx, rec_cnt);
                    check_value("rec_w_addr", bus_a.w_addr, rec_cnt * 3 * N + cur.bias);
                    rec_cnt++;
                end
            end
            if (bus_a.act_valid) begin
                check_value("act_no_mac", bus_a.mac_en, 0);
                if (!in_act) begin
                    act_ref = {bus_a.gate, bus_a.neuron, bus_a.bias_addr, bus_a.w_addr, bus_a.x_idx};
                    in_act  = 1'b1;
                end else begin
                    check_value("act_stable", {bus_a.gate, bus_a.neuron, bus_a.bias_addr,
                                               bus_a.w_addr, bus_a.x_idx}, act_ref);
                end
                if (bus_a.act_ready) begin
                    in_act = 1'b0;
                    hs_cnt++;
                    if (bus_a.state_we) we_cnt++;
                    if (exp_q.size() == 0) check_value("hs_queue", exp_q.size(), 1);
                    else begin
                        cur = exp_q.pop_front();
                        check_value("hs_gate", bus_a.gate, cur.gate);
                        check_value("hs_neuron", bus_a.neuron, cur.neuron);
                        check_value("hs_bias", bus_a.bias_addr, cur.bias);
                        check_value("hs_w_addr", bus_a.w_addr, cur.waddr);
                        check_value("hs_state_we", bus_a.state_we, cur.we);
                        check_value("hs_in_macs", in_cnt, M);
                        check_value("hs_rec_macs", rec_cnt, N);
                    end
                end
            end
            if (bus_a.state_we && !(bus_a.act_valid && bus_a.act_ready))
                check_value("we_outside_hs", bus_a.state_we, 0);
            if (bus_a.busy) busy_run++;
            else begin
                if (bus_a.done) begin
                    done_cnt++;
                    if (done_q.size() == 0) check_value("done_queue", done_q.size(), 1);
                    else begin
                        dexp = done_q.pop_front();
                        check_value("done_cycle", cyc, dexp.cyc);
                        check_value("busy_len", busy_run, dexp.busy_len);
                    end
                end
                busy_run = 0;
            end
        end
    end

    function automatic logic any_out_a();
        return |{bus_a.busy, bus_a.done, bus_a.mac_clr, bus_a.mac_en, bus_a.mac_sel, bus_a.gate,
                 bus_a.neuron, bus_a.x_idx, bus_a.bias_addr, bus_a.w_addr, bus_a.act_valid,
                 bus_a.state_we};
    endfunction

    task automatic wait_done_a(input int bound);
        int k = 0;
        while (!bus_a.done && k < bound) begin
            @(negedge clk);
            k++;
        end
        check_value("done_seen", bus_a.done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_step(input int stall);
        stall_cfg = stall;
        hs_cnt    = 0;
        we_cnt    = 0;
        done_cnt  = 0;
        @(posedge clk);
        #1;
        push_step(cyc, stall);
        bus_a.start = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        wait_done_a(LAT + 3 * N * stall + 50);
        check_value("hs_count", hs_cnt, 3 * N);
        check_value("we_count", we_cnt, N);
        check_value("done_count", done_cnt, 1);
        check_value("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int k;
        int busy_seen;
        int we_b;
        int av_b;
        bus_a.start     = 1'b0;
        bus_b.start     = 1'b0;
        bus_b.act_ready = 1'b1;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("reset_outs", any_out_a(), 0);
        check_value("reset_busy_b", bus_b.busy, 0);
`ifdef GRU_STALL_CNT_EN
        check_value("reset_stall_cnt", bus_a.stall_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // T1/T2: unstalled step with address monitoring
        run_step(0);

        // T3: 7 stall cycles at every ACT
        run_step(STALL);
`ifdef GRU_STALL_CNT_EN
        check_value("stall_cnt", bus_a.stall_cnt, 3 * N * STALL);
`endif

        // T4: start re-pulsed mid-step and on the done cycle
        stall_cfg = 0;
        done_cnt  = 0;
        @(posedge clk);
        #1;
        s = cyc;
        push_step(s, 0);
        bus_a.start = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        bus_a.start = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        k = 0;
        while (cyc < s + LAT && k < LAT + 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_value("t4_done_on_cycle", bus_a.done, 1);
        bus_a.start = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_a.busy) busy_seen++;
        end
        check_value("t4_no_restart", busy_seen, 0);
        check_value("t4_one_done", done_cnt, 1);
`ifdef GRU_STALL_CNT_EN
        check_value("stall_cnt_cleared", bus_a.stall_cnt, 0);
`endif

        // T5: reset during recurrent MACs of gate R
        done_cnt = 0;
        @(posedge clk);
        #1;
        push_step(cyc, 0);
        bus_a.start = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        k = 0;
        while (!(bus_a.gate == 2'd1 && bus_a.mac_en && bus_a.mac_sel) && k < LAT) begin
            @(negedge clk);
            k++;
        end
        check_value("t5_reached_rec_r", bus_a.mac_sel, 1);
        rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        #1;
        check_value("t5_outs_zero", any_out_a(), 0);
        repeat (2) @(posedge clk);
        #1;
        check_value("t5_outs_held", any_out_a(), 0);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_value("t5_no_done", done_cnt, 0);
        run_step(0);

        // T6: M=N=1 instance
        @(posedge clk);
        #1;
        s = cyc;
        bus_b.start = 1'b1;
        @(posedge clk);
        #1;
        bus_b.start = 1'b0;
        we_b = 0;
        av_b = 0;
        k    = 0;
        while (!bus_b.done && k < 100) begin
            @(negedge clk);
            if (bus_b.state_we) begin
                we_b++;
                check_value("t6_we_neuron", bus_b.neuron, 0);
            end
            if (bus_b.act_valid) av_b++;
            k++;
        end
        check_value("t6_done_seen", bus_b.done, 1);
        check_value("t6_latency", cyc - s, 13);
        check_value("t6_we_count", we_b, 1);
        check_value("t6_act_count", av_b, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
